// File: rtl/store_merge_unit_pkg.sv
// Shared encodings for the store merge unit: operand sizes, FSM states and
// the word-alignment mask applied to store byte addresses.
package store_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFS_W  = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // ANDed onto the byte offset to form the word address of the RAM port
  localparam logic [OFS_W-1:0] WORD_ALIGN_MASK = 2'b00;

  // Half stores must sit on an even byte, word stores on a word boundary
  function automatic logic misaligned(input size_e sz, input logic [OFS_W-1:0] ofs);
    return ((sz == SZ_HALF) && ofs[0]) || ((sz == SZ_WORD) && (ofs != 2'b00));
  endfunction

endpackage

// File: rtl/store_merge_unit_if.sv
// Request and RAM-port bundle of the store merge unit. The master side is the
// pipeline plus data RAM; the slave side is store_merge_unit.
interface store_merge_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata,
    input  req_ready, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata,
    output req_ready, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/store_merge_unit_lane_merge.sv
// Combinational little-endian lane merge: overlays a truncated store operand
// onto the word read back from RAM.
module lane_merge
  import store_pkg::*;
(
  input  logic [DATA_W-1:0] old_word_i,
  input  logic [DATA_W-1:0] operand_i,
  input  size_e             size_i,
  input  logic [OFS_W-1:0]  ofs_i,
  output logic [DATA_W-1:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{ofs_i, 3'b000} +: 8]        = operand_i[7:0];
      // ofs_i[0] deliberately ignored: half lane is chosen by bit 1 only
      SZ_HALF: merged_o[{ofs_i[1], 4'b0000} +: 16]   = operand_i[15:0];
      SZ_WORD: merged_o                              = operand_i;
      default: merged_o                              = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store-path narrowing and read-modify-write merge unit for the memory stage.
// Optional STORE_MISALIGN_TRAP_EN rejects misaligned half/word stores via ERR.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  store_merge_unit_if.slave  bus
);

  state_e            state_q,     state_d;
  logic [OFS_W-1:0]  ofs_q,       ofs_d;
  logic [DATA_W-1:0] data_q,      data_d;
  size_e             size_q,      size_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;

  size_e             req_size_c;
  logic              accept_c;
  logic              reject_c;
  logic [DATA_W-1:0] merged_c;

  assign req_size_c = size_e'(bus.req_size);
  assign accept_c   = bus.req_valid && (state_q == ST_IDLE);

`ifdef STORE_MISALIGN_TRAP_EN
  assign reject_c = (req_size_c == SZ_RSVD) || misaligned(req_size_c, bus.req_addr[1:0]);
`else
  assign reject_c = (req_size_c == SZ_RSVD);
`endif

  lane_merge u_lane_merge (
    .old_word_i (bus.mem_rdata),
    .operand_i  (data_q),
    .size_i     (size_q),
    .ofs_i      (ofs_q),
    .merged_o   (merged_c)
  );

  // Next-state and registered-output decode; strobes default low
  always_comb begin
    state_d     = state_q;
    ofs_d       = ofs_q;
    data_d      = data_q;
    size_d      = size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_en_d = 1'b0;
    mem_wr_en_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          ofs_d      = bus.req_addr[1:0];
          data_d     = bus.req_data;
          size_d     = req_size_c;
          mem_addr_d = {bus.req_addr[ADDR_W-1:2], bus.req_addr[1:0] & WORD_ALIGN_MASK};
          if (reject_c) begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (req_size_c == SZ_WORD) begin
            state_d     = ST_WRITE;
            mem_wr_en_d = 1'b1;
            done_d      = 1'b1;
            mem_wdata_d = bus.req_data;
          end else begin
            state_d     = ST_READ;
            mem_rd_en_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        state_d = ST_MERGE;
      end
      // RAM data is valid this cycle; merge and register it for the write
      ST_MERGE: begin
        state_d     = ST_WRITE;
        mem_wr_en_d = 1'b1;
        done_d      = 1'b1;
        mem_wdata_d = merged_c;
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ofs_q       <= '0;
      data_q      <= '0;
      size_q      <= SZ_BYTE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ofs_q       <= ofs_d;
      data_q      <= data_d;
      size_q      <= size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-path data narrowing and merge unit for the CPU memory stage. It truncates a 32-bit store operand to byte, halfword or word width. Sub-word stores into the word-only data memory are done as read-modify-write. It is the store-side counterpart of the load-side sign extension and sits between the EX/MEM pipeline register and the data RAM port.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of requests and the memory port.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_addr  input  ADDR_W  byte address of the store.
- req_data  input  32  store operand, right-justified.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- done  output  1  one-cycle pulse when the request completes.
- err  output  1  one-cycle pulse with done when the request was rejected.
- mem_addr  output  ADDR_W  word address: {req_addr[ADDR_W-1:2], 2'b00}.
- mem_rd_en  output  1  synchronous RAM read strobe.
- mem_rdata  input  32  RAM read data, valid the cycle after mem_rd_en.
- mem_wr_en  output  1  RAM write strobe, one cycle.
- mem_wdata  output  32  merged write word.

## Operation
- FSM states: IDLE, READ, MERGE, WRITE, ERR. req_ready = (state == IDLE).
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. addr/data/size are registered at acceptance. Inputs are ignored otherwise.
- Word request: IDLE -> WRITE. mem_wdata = req_data.
- Byte or half request: IDLE -> READ -> MERGE -> WRITE.
  - READ asserts mem_rd_en.
  - MERGE captures mem_rdata.
  - WRITE drives the merged word.
- Truncation: byte uses req_data[7:0]; half uses req_data[15:0]. Upper operand bits are discarded.
- Lanes are little-endian:
  - byte k = addr[1:0] replaces bits [8k+7:8k];
  - half h = addr[1] replaces bits [16h+15:16h];
  - all other bits keep the read value.
- WRITE: mem_wr_en = 1 and done = 1 for one cycle, then IDLE.
- Reserved size 11: IDLE -> ERR; done = err = 1 for one cycle, no memory access, then IDLE.
- All outputs are registered. Reset value of every output is 0 except req_ready, which is 1 (combinational from IDLE).

## Timing
- Acceptance edge = cycle 0.
- Word store: mem_wr_en/done in cycle 1. Throughput is one store per 2 cycles.
- Sub-word store timing:
  - mem_rd_en in cycle 1;
  - rdata captured at end of cycle 2;
  - mem_wr_en/done in cycle 3.
  - Throughput is one store per 4 cycles.
- Error: done/err in cycle 1.
- Reset mid-operation: the FSM goes to IDLE asynchronously and mem_wr_en/mem_rd_en drop immediately. The in-flight store is abandoned with no write and no done.
- req_valid held high across done: the next request is accepted on the first edge after returning to IDLE, never in the WRITE cycle.

## Configuration
- STORE_MISALIGN_TRAP_EN defined: the following requests take the ERR path (done = err = 1, no RAM access):
  - half with addr[0] = 1;
  - word with addr[1:0] != 0.
- Undefined: misalignment is not checked.
  - Half uses lane addr[1] (addr[0] is ignored).
  - Word ignores addr[1:0].
  - err pulses only for size 11.

## Structure
- Package store_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - the FSM state encoding constants;
  - the word-align mask constant.
- Sub-module lane_merge: purely combinational. Inputs are old word, new operand, size and addr[1:0]; output is the merged word. It is instantiated once and drives the WRITE-cycle data.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF -> cycle 1: mem_wr_en=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done=1; no mem_rd_en.
- Byte store, addr 0x203, data 0x123456AB, RAM word 0x11223344 -> mem_rd_en cycle 1, write in cycle 3 with mem_wdata=0xAB223344, done=1.
- Half store, addr 0x202, data 0xFFFFBEEF, RAM word 0x11223344 -> mem_wdata=0xBEEF3344 in cycle 3.
- Size 11, any addr -> done=err=1 in cycle 1; mem_rd_en and mem_wr_en never assert.
- Half store at addr 0x201:
  - with STORE_MISALIGN_TRAP_EN -> err=1, no RAM access;
  - without -> lane 0 written, mem_wdata[15:0]=operand.
- rst asserted during MERGE of a byte store -> outputs 0 immediately, no mem_wr_en. The next request after reset release completes normally.
